// File: rtl/rfb_scan_scheduler_if.sv
// Interface between the RFB scan scheduler and its surroundings: rotation pulses,
// the dual-port RFB read path and the column-pair handshake to the HUB75 converter.
interface rfb_scan_scheduler_if #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int SCAN_RATE      = 32,
  parameter int NUM_ROWS       = 64
);
  localparam int AW = $clog2(ROTATIONAL_RES);
  localparam int RW = $clog2(SCAN_RATE);

  logic                           angle_tick_in;
  logic                           angle_sync_in;
  logic [AW+RW-1:0]               rfb_addr0_out;
  logic [AW+RW-1:0]               rfb_addr1_out;
  logic [NUM_ROWS-1:0]            rfb_data0_in;
  logic [NUM_ROWS-1:0]            rfb_data1_in;
  logic [1:0][RW-1:0]             radii_out;
  logic [1:0][NUM_ROWS-1:0]       rfb_cols_out;
  logic                           cols_valid_out;
  logic                           cols_ready_in;
  logic [AW-1:0]                  angle_out;
  logic [15:0]                    overrun_count_out;
  logic                           busy_out;

  modport master (
    input  angle_tick_in, angle_sync_in, rfb_data0_in, rfb_data1_in, cols_ready_in,
    output rfb_addr0_out, rfb_addr1_out, radii_out, rfb_cols_out, cols_valid_out,
           angle_out, overrun_count_out, busy_out
  );

  modport slave (
    output angle_tick_in, angle_sync_in, rfb_data0_in, rfb_data1_in, cols_ready_in,
    input  rfb_addr0_out, rfb_addr1_out, radii_out, rfb_cols_out, cols_valid_out,
           angle_out, overrun_count_out, busy_out
  );
endinterface

// File: rtl/rfb_scan_scheduler.sv
// Walks every radius of the current angular slice, reading both half-panel columns
// from the RFB and handing each pair to the converter; tracks angle and overruns.
module rfb_scan_scheduler #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int SCAN_RATE      = 32,
  parameter int NUM_ROWS       = 64,
  parameter int BRAM_LATENCY   = 2
) (
  input logic                  clk_in,
  input logic                  rst_in,
  rfb_scan_scheduler_if.master bus
);
  localparam int AW = $clog2(ROTATIONAL_RES);
  localparam int RW = $clog2(SCAN_RATE);
  localparam int CW = $clog2(BRAM_LATENCY + 1);
  localparam logic [AW-1:0] HALF_TURN   = AW'(ROTATIONAL_RES / 2);
  localparam logic [RW-1:0] LAST_RADIUS = RW'(SCAN_RATE - 1);
  localparam logic [CW-1:0] LAT_LOAD    = CW'(BRAM_LATENCY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, PRESENT, HOLD} state_t;

  state_t                   state, state_next;
  logic [AW-1:0]            angle, slice_angle;
  logic [RW-1:0]            radius, slice_radius;
  logic [CW-1:0]            lat_cnt;
  logic                     pending_tick, pending_sync;
  logic [AW+RW-1:0]         addr0, addr1;
  logic [1:0][NUM_ROWS-1:0] cols;
  logic [1:0][RW-1:0]       radii;
  logic [15:0]              overrun_count;
  logic                     load_issue, new_slice, scanning;
  logic                     tick_event, sync_event, want_tick, want_sync;

  // A sync in the same cycle as a tick swallows the tick entirely.
  assign sync_event = bus.angle_sync_in;
  assign tick_event = bus.angle_tick_in & ~bus.angle_sync_in;
  assign scanning   = state inside {ISSUE, WAIT_RD, PRESENT};
  assign want_sync  = pending_sync | sync_event;
  assign want_tick  = pending_tick | tick_event;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    load_issue   = 1'b0;
    new_slice    = 1'b0;
    slice_angle  = angle;
    slice_radius = radius;
    case (state)
      IDLE: begin
        if (sync_event) begin
          state_next   = ISSUE;
          load_issue   = 1'b1;
          new_slice    = 1'b1;
          slice_angle  = '0;
          slice_radius = '0;
        end
      end
      ISSUE:   state_next = WAIT_RD;
      WAIT_RD: if (lat_cnt == CW'(1)) state_next = PRESENT;
      PRESENT: begin
        if (bus.cols_ready_in) begin
          if (want_sync || want_tick) begin
            // Late slice start: the rest of the old slice is abandoned.
            state_next   = ISSUE;
            load_issue   = 1'b1;
            new_slice    = 1'b1;
            slice_angle  = want_sync ? '0 : angle + AW'(1);
            slice_radius = '0;
          end else if (radius == LAST_RADIUS) begin
            state_next = HOLD;
          end else begin
            state_next   = ISSUE;
            load_issue   = 1'b1;
            slice_radius = radius + RW'(1);
          end
        end
      end
      HOLD: begin
        if (sync_event || tick_event) begin
          state_next   = ISSUE;
          load_issue   = 1'b1;
          new_slice    = 1'b1;
          slice_angle  = sync_event ? '0 : angle + AW'(1);
          slice_radius = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      angle         <= '0;
      radius        <= '0;
      lat_cnt       <= '0;
      pending_tick  <= 1'b0;
      pending_sync  <= 1'b0;
      addr0         <= '0;
      addr1         <= '0;
      cols          <= '0;
      radii         <= '0;
      overrun_count <= '0;
    end else begin
      if (load_issue) begin
        angle  <= slice_angle;
        radius <= slice_radius;
        addr0  <= {slice_angle, slice_radius};
        addr1  <= {slice_angle + HALF_TURN, slice_radius};
      end

      if (state == ISSUE)        lat_cnt <= LAT_LOAD;
      else if (state == WAIT_RD) lat_cnt <= lat_cnt - CW'(1);

      if (state == WAIT_RD && lat_cnt == CW'(1)) begin
        cols  <= {bus.rfb_data1_in, bus.rfb_data0_in};
        radii <= {radius, radius};
      end

      // Events seen in the handshake cycle are folded into the slice decision above.
      if (new_slice) begin
        pending_tick <= 1'b0;
        pending_sync <= 1'b0;
      end else if (scanning) begin
        if (sync_event)      pending_sync <= 1'b1;
        else if (tick_event) pending_tick <= 1'b1;
      end

      if (scanning && tick_event && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  always_comb begin
    bus.cols_valid_out    = (state == PRESENT);
    bus.busy_out          = scanning;
    bus.rfb_addr0_out     = addr0;
    bus.rfb_addr1_out     = addr1;
    bus.rfb_cols_out      = cols;
    bus.radii_out         = radii;
    bus.angle_out         = angle;
    bus.overrun_count_out = overrun_count;
  end
endmodule

// File: tb/tb_rfb_scan_scheduler.sv
// Bench for rfb_scan_scheduler: a two-cycle RFB model feeds the DUT, expected pairs
// go into a queue as slices are started and are checked at every handshake.
module tb_rfb_scan_scheduler;
  localparam int RES = 1024;
  localparam int SR  = 32;
  localparam int NR  = 64;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rfb_scan_scheduler_if #(.ROTATIONAL_RES(RES), .SCAN_RATE(SR), .NUM_ROWS(NR)) bus ();

  rfb_scan_scheduler #(
    .ROTATIONAL_RES(RES), .SCAN_RATE(SR), .NUM_ROWS(NR), .BRAM_LATENCY(LAT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  typedef struct {
    int angle;
    int radius;
  } pair_t;

  typedef struct {
    logic rst, tick, sync;
    logic busy, valid;
    int   angle, addr0, addr1;
  } vec_t;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    model_angle = 0;
  int    ovr_model = 0;

  function automatic logic [63:0] mem_word(input logic side, input logic [14:0] a);
    return {(side ? 32'hB1B1_0000 : 32'hA0A0_0000) ^ {17'd0, a}, 17'd0, a};
  endfunction

  // RFB model: data appears two cycles after the address.
  logic [63:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0            <= mem_word(1'b0, bus.rfb_addr0_out);
    pipe1            <= mem_word(1'b1, bus.rfb_addr1_out);
    bus.rfb_data0_in <= pipe0;
    bus.rfb_data1_in <= pipe1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slice(input int a, input int count);
    for (int r = 0; r < count; r++) exp_q.push_back('{a % RES, r});
  endtask

  task automatic wait_hold();
    int cyc = 0;
    while (bus.busy_out && cyc < 400) begin
      step();
      cyc++;
    end
    check("hold_reached", bus.busy_out, 1'b0);
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!bus.cols_valid_out && cyc < 20) begin
      step();
      cyc++;
    end
    check("valid_seen", bus.cols_valid_out, 1'b1);
  endtask

  // From HOLD: one tick per slice, each extra slice cut short by an overrun tick
  // so it yields only its radius-0 pair; the target slice is scanned in full.
  task automatic ff_to(input int target);
    int n = (target - model_angle + RES) % RES;
    for (int k = 1; k < n; k++) exp_q.push_back('{(model_angle + k) % RES, 0});
    push_slice(target, SR);
    bus.angle_tick_in = 1'b1;
    step();
    for (int k = 1; k < n; k++) begin
      step();
      bus.angle_tick_in = 1'b0;
      repeat (3) step();
      bus.angle_tick_in = 1'b1;
    end
    bus.angle_tick_in = 1'b0;
    ovr_model  += n - 1;
    model_angle = target;
    wait_hold();
    check("ff_angle", bus.angle_out, target);
    check("ff_overrun", bus.overrun_count_out, ovr_model);
  endtask

  // Scoreboard: every accepted pair must match the next expected {angle, radius}.
  always @(negedge clk) begin
    pair_t       p;
    logic [14:0] a0, a1;
    if (!rst && bus.cols_valid_out && bus.cols_ready_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 1'b1, 1'b0);
      end else begin
        p  = exp_q.pop_front();
        a0 = {10'(p.angle), 5'(p.radius)};
        a1 = {10'((p.angle + RES / 2) % RES), 5'(p.radius)};
        check("pair_col0", bus.rfb_cols_out[0], mem_word(1'b0, a0));
        check("pair_col1", bus.rfb_cols_out[1], mem_word(1'b1, a1));
        check("pair_radius0", bus.radii_out[0], p.radius);
        check("pair_radius1", bus.radii_out[1], p.radius);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    bus.angle_tick_in = 1'b0;
    bus.angle_sync_in = 1'b0;
    bus.cols_ready_in = 1'b1;

    //          rst   tick  sync  busy  valid angle addr0 addr1
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0,    0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,    0,    0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0,    0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,    0,    16384};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0,    16384};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0,    16384};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0,    0,    16384};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,    1,    16385};

    for (int i = 0; i < 8; i++) begin
      rst               = vecs[i].rst;
      bus.angle_tick_in = vecs[i].tick;
      bus.angle_sync_in = vecs[i].sync;
      if (vecs[i].sync) push_slice(0, SR);
      step();
      bus.angle_tick_in = 1'b0;
      bus.angle_sync_in = 1'b0;
      check($sformatf("vec%0d_busy", i), bus.busy_out, vecs[i].busy);
      check($sformatf("vec%0d_valid", i), bus.cols_valid_out, vecs[i].valid);
      check($sformatf("vec%0d_angle", i), bus.angle_out, vecs[i].angle);
      check($sformatf("vec%0d_addr0", i), bus.rfb_addr0_out, vecs[i].addr0);
      check($sformatf("vec%0d_addr1", i), bus.rfb_addr1_out, vecs[i].addr1);
      check($sformatf("vec%0d_overrun", i), bus.overrun_count_out, 0);
      if (i == 0) begin
        check("reset_cols", bus.rfb_cols_out, 0);
        check("reset_radii", bus.radii_out, 0);
      end
    end

    wait_hold();
    check("scan0_queue_drained", exp_q.size(), 0);
    check("scan0_valid_low", bus.cols_valid_out, 1'b0);
    check("scan0_angle", bus.angle_out, 0);

    // Backpressure on the first pair of slice 1.
    bus.cols_ready_in = 1'b0;
    bus.angle_tick_in = 1'b1;
    push_slice(1, SR);
    step();
    bus.angle_tick_in = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.cols_valid_out, 1'b1);
      check("bp_col0", bus.rfb_cols_out[0], mem_word(1'b0, 15'd32));
      check("bp_col1", bus.rfb_cols_out[1], mem_word(1'b1, 15'(513 * 32)));
      check("bp_radii", bus.radii_out, 0);
      step();
    end
    bus.cols_ready_in = 1'b1;
    step();
    check("bp_valid_drop", bus.cols_valid_out, 1'b0);
    wait_hold();
    model_angle = 1;

    // Simultaneous tick and sync in HOLD at angle 300.
    ff_to(300);
    bus.angle_tick_in = 1'b1;
    bus.angle_sync_in = 1'b1;
    push_slice(0, SR);
    step();
    bus.angle_tick_in = 1'b0;
    bus.angle_sync_in = 1'b0;
    check("ts_angle", bus.angle_out, 0);
    check("ts_addr1", bus.rfb_addr1_out, 16384);
    check("ts_overrun", bus.overrun_count_out, ovr_model);
    wait_hold();
    model_angle = 0;

    // Side-1 wrap: 511 -> 512 puts side 1 at angle 0.
    ff_to(511);
    bus.angle_tick_in = 1'b1;
    push_slice(512, SR);
    step();
    bus.angle_tick_in = 1'b0;
    check("w511_angle", bus.angle_out, 512);
    check("w511_side0", bus.rfb_addr0_out >> 5, 512);
    check("w511_side1", bus.rfb_addr1_out >> 5, 0);
    wait_hold();
    model_angle = 512;

    // Angle wrap: 1023 -> 0.
    ff_to(1023);
    bus.angle_tick_in = 1'b1;
    push_slice(0, SR);
    step();
    bus.angle_tick_in = 1'b0;
    check("w1023_angle", bus.angle_out, 0);
    check("w1023_side1", bus.rfb_addr1_out >> 5, 512);
    wait_hold();
    model_angle = 0;

    // Reset while waiting on the read for radius 2 of slice 1.
    exp_q.push_back('{1, 0});
    exp_q.push_back('{1, 1});
    bus.angle_tick_in = 1'b1;
    step();
    bus.angle_tick_in = 1'b0;
    repeat (9) step();
    check("rst_pre_busy", bus.busy_out, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_valid", bus.cols_valid_out, 1'b0);
    check("rst_busy", bus.busy_out, 1'b0);
    check("rst_angle", bus.angle_out, 0);
    check("rst_addr0", bus.rfb_addr0_out, 0);
    check("rst_addr1", bus.rfb_addr1_out, 0);
    check("rst_cols", bus.rfb_cols_out, 0);
    check("rst_radii", bus.radii_out, 0);
    check("rst_overrun", bus.overrun_count_out, 0);
    step();
    rst = 1'b0;
    ovr_model = 0;
    bus.angle_tick_in = 1'b1;
    repeat (3) step();
    bus.angle_tick_in = 1'b0;
    check("rst_tick_ignored_busy", bus.busy_out, 1'b0);
    check("rst_tick_ignored_angle", bus.angle_out, 0);
    bus.angle_sync_in = 1'b1;
    push_slice(0, SR);
    step();
    bus.angle_sync_in = 1'b0;
    check("rst_sync_busy", bus.busy_out, 1'b1);
    check("rst_sync_addr0", bus.rfb_addr0_out, 0);
    wait_hold();

    // Overrun: tick during radius 5 of slice 1.
    for (int r = 0; r < 6; r++) exp_q.push_back('{1, r});
    push_slice(2, SR);
    bus.angle_tick_in = 1'b1;
    step();
    bus.angle_tick_in = 1'b0;
    repeat (20) step();
    bus.angle_tick_in = 1'b1;
    step();
    bus.angle_tick_in = 1'b0;
    check("ovr1_count", bus.overrun_count_out, 1);
    repeat (3) step();
    check("ovr1_angle", bus.angle_out, 2);
    check("ovr1_addr0", bus.rfb_addr0_out, 2 * 32);
    check("ovr1_busy", bus.busy_out, 1'b1);
    wait_hold();

    // Three ticks within slice 3: one angle step, three overruns.
    exp_q.push_back('{3, 0});
    push_slice(4, SR);
    bus.angle_tick_in = 1'b1;
    step();
    repeat (3) step();
    bus.angle_tick_in = 1'b0;
    step();
    check("ovr3_angle", bus.angle_out, 4);
    check("ovr3_count", bus.overrun_count_out, 4);
    wait_hold();
    check("ovr3_hold_angle", bus.angle_out, 4);

    check("final_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rfb_scan_scheduler.md
Name: rfb_scan_scheduler

Overview:
- Sequences reads from the rotational frame buffer (RFB) for the spinning panel.
- Each angular slice is split between two half-panels: side 0 reads angle A, side 1 reads angle A+ROTATIONAL_RES/2. For every slice the block walks all SCAN_RATE radii.
- For each radius it reads both RFB columns with a fixed BRAM latency, then presents the pair to the column-to-HUB75 converter over a valid/ready handshake.
- It tracks the angle from rotation tick/sync pulses and counts slices that overran their time budget.

Parameters:
- ROTATIONAL_RES, 1024: angular slices per revolution; power of two, at least 2.
- SCAN_RATE, 32: radii per slice; power of two.
- NUM_ROWS, 64: bits per RFB column word.
- BRAM_LATENCY, 2: cycles from address to read data, range 1..4.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: reset, asynchronous, active-high.
- angle_tick_in, input, 1: one-cycle pulse; advance to the next angular slice.
- angle_sync_in, input, 1: one-cycle index pulse; next slice is angle 0.
- rfb_addr0_out, output, $clog2(ROTATIONAL_RES)+$clog2(SCAN_RATE): side-0 read address {angle, radius}.
- rfb_addr1_out, output, same width: side-1 read address {angle+ROTATIONAL_RES/2 mod ROTATIONAL_RES, radius}.
- rfb_data0_in, input, NUM_ROWS: side-0 read data.
- rfb_data1_in, input, NUM_ROWS: side-1 read data.
- radii_out, output, [1:0][$clog2(SCAN_RATE)-1:0]: radius of the presented pair; both entries are equal.
- rfb_cols_out, output, [1:0][NUM_ROWS-1:0]: captured column pair.
- cols_valid_out, output, 1: pair valid.
- cols_ready_in, input, 1: converter accepts the pair.
- angle_out, output, $clog2(ROTATIONAL_RES): angle of the current slice.
- overrun_count_out, output, 16: saturating count of overrun slices.
- busy_out, output, 1: high in any state other than IDLE or HOLD.

Behaviour:
- Reset (async, rst_in=1): every output is 0; state IDLE; angle=0; radius=0; pending_tick=0; pending_sync=0.
- IDLE:
  - Ignores angle_tick_in until the first angle_sync_in.
  - On angle_sync_in: angle=0, radius=0, go to ISSUE.
- ISSUE (1 cycle):
  - Drive both addresses from the current angle and radius.
  - Load the latency counter with BRAM_LATENCY; go to WAIT_RD.
  - Addresses hold their value until the next ISSUE.
- WAIT_RD:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 0, capture rfb_data0_in/rfb_data1_in into rfb_cols_out, set radii_out, go to PRESENT.
  - cols_valid_out rises BRAM_LATENCY+1 cycles after ISSUE.
- PRESENT:
  - cols_valid_out=1; rfb_cols_out and radii_out are stable while valid and not ready.
  - On cols_valid_out & cols_ready_in: drop valid the next cycle, then take the first matching case:
    - pending_sync or pending_tick set: enter the new slice (see tick/sync rules), radius=0, go to ISSUE. Any remaining radii of the old slice are dropped.
    - radius==SCAN_RATE-1: go to HOLD.
    - otherwise: radius+1, go to ISSUE.
- HOLD:
  - Wait for a tick or sync.
  - angle_tick_in: angle+1, wrapping ROTATIONAL_RES-1 to 0; radius=0; go to ISSUE.
  - angle_sync_in: angle=0.
- Tick/sync outside HOLD/IDLE:
  - Set the pending flag. The flag is consumed at the next slice start.
  - A tick arriving while radius<SCAN_RATE-1, or before the last handshake completes, is an overrun: overrun_count_out+1, saturating at 16'hFFFF.
  - A second tick while pending still counts as an overrun and advances the angle by 1 only; no double-skip.
- Simultaneous sync and tick in the same cycle: sync wins; angle=0; one event recorded.
- Sync and tick both pending: new angle=0.
- angle_out updates on slice entry. rfb_addr1_out angle always equals (angle_out+ROTATIONAL_RES/2) mod ROTATIONAL_RES.
- rst_in asserted mid-read or mid-PRESENT: immediate return to the reset state; cols_valid_out drops asynchronously. After reset the block waits in IDLE for the next sync.
- Throughput: one pair per BRAM_LATENCY+2 cycles when cols_ready_in is held high.

Test Plan:
- Reset then sync, cols_ready_in=1, BRAM_LATENCY=2:
  - rfb_addr0_out={0,0} and rfb_addr1_out={512,0} in the ISSUE cycle.
  - cols_valid_out high 3 cycles later.
  - 32 handshakes with radii 0..31, then HOLD with busy_out=0.
- Ticks in HOLD across a wrap:
  - angle 1023 + tick gives angle_out=0 and rfb_addr1_out angle=512.
  - angle 511 + tick gives side-1 angle 0.
- Backpressure: hold cols_ready_in=0 for 10 cycles in PRESENT -> cols_valid_out, rfb_cols_out and radii_out stay constant; accept on cycle 11.
- Overrun:
  - Tick at radius 5: current pair completes, next ISSUE has radius 0 with angle+1, overrun_count_out=1.
  - Three ticks within one slice: angle advances by 1, count is 3.
- Simultaneous tick+sync at angle 300 in HOLD -> angle_out=0, no overrun counted.
- rst_in asserted while in WAIT_RD:
  - All outputs are 0 at once.
  - Ticks before a sync are ignored.
  - After the sync, radius restarts at 0.
